// File: rtl/ibex_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package ibex_pkg;

   localparam int XLEN  = 32;
   localparam int ITER  = 32;
   localparam int CNT_W = $clog2(ITER);

   // Operator encoding as presented by the decoder.
   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;

   // ALU operator codes the unit may drive onto the shared ALU.
   localparam logic [5:0] ALU_ADD  = 6'h00;
   localparam logic [5:0] ALU_SGEU = 6'h16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ABS  = 2'd1,
      CALC = 2'd2,
      FIX  = 2'd3
   } md_state_e;

   // DIV and REM share the MSB of the operator encoding.
   function automatic logic md_is_div(md_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/ibex_multdiv_negate.sv
// Conditional two's complement: result = neg ? -value : value.
module ibex_multdiv_negate #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] result
);

   assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/ibex_multdiv_slow.sv
// Iterative radix-2 multiply/divide unit (RV32M), 32 iterations per op.
// Division borrows the shared ALU as a subtract/compare engine; multiply
// uses its own 33-bit adder.
// Optional: define MULTDIV_DIVZERO_SHORTCUT_EN to skip the iterations on
// division by zero (result valid two cycles after the request).
module ibex_multdiv_slow
   import ibex_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            io_en_i,
   input  logic            io_kill_i,
   input  logic [1:0]      io_md_operator_i,
   input  logic [1:0]      io_signed_mode_i,
   input  logic [XLEN-1:0] io_operand_a_i,
   input  logic [XLEN-1:0] io_operand_b_i,
   output logic            io_alu_active_o,
   output logic [5:0]      io_alu_operator_o,
   output logic [XLEN-1:0] io_alu_operand_a_o,
   output logic [XLEN-1:0] io_alu_operand_b_o,
   input  logic [XLEN-1:0] io_alu_adder_result_i,
   input  logic            io_alu_comparison_result_i,
   output logic            io_valid_o,
   output logic [XLEN-1:0] io_result_o
);

   md_state_e         state_q, state_d;
   md_op_e            op_q;
   logic [1:0]        mode_q;
   logic [XLEN-1:0]   a_q, b_q;
   logic              neg_q_q, neg_r_q;
   logic [XLEN:0]     acc_hi_q;   // MUL: upper product; DIV: partial remainder
   logic [XLEN-1:0]   acc_lo_q;   // MUL: multiplier/lower product; DIV: dividend/quotient
   logic [CNT_W-1:0]  cnt_q;

   logic              is_div, sa, sb, b_zero, ge, valid;
   logic [XLEN:0]     abs_a, abs_b, mul_sum, rem_sh;
   logic [2*XLEN-1:0] prod_fixed;
   logic [XLEN-1:0]   quot_fixed, rem_fixed, result_raw;

   assign is_div = md_is_div(op_q);
   assign sa     = mode_q[0] & a_q[XLEN-1];
   assign sb     = mode_q[1] & b_q[XLEN-1];

   // Magnitudes of the latched operands, sign-extended to 33 bits per mode.
   ibex_multdiv_negate #(.WIDTH(XLEN+1)) u_abs_a (
      .neg(sa), .value({sa, a_q}), .result(abs_a)
   );
   ibex_multdiv_negate #(.WIDTH(XLEN+1)) u_abs_b (
      .neg(sb), .value({sb, b_q}), .result(abs_b)
   );

   assign b_zero  = (abs_b == '0);
   assign mul_sum = acc_hi_q + (acc_lo_q[0] ? abs_a : '0);
   assign rem_sh  = {acc_hi_q[XLEN-1:0], acc_lo_q[XLEN-1]};
   // The carried-out bit makes the remainder exceed any 32-bit divisor.
   assign ge      = rem_sh[XLEN] | io_alu_comparison_result_i;

   assign io_alu_active_o    = (state_q == CALC) && is_div;
   assign io_alu_operator_o  = io_alu_active_o ? ALU_SGEU : ALU_ADD;
   assign io_alu_operand_a_o = rem_sh[XLEN-1:0];
   assign io_alu_operand_b_o = abs_b[XLEN-1:0];

   // Next-state logic; an abort in any busy state returns to IDLE silently.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_d = state_q;
      valid   = 1'b0;
      case (state_q)
         IDLE: if (io_en_i && !io_kill_i) state_d = ABS;
         ABS: begin
`ifdef MULTDIV_DIVZERO_SHORTCUT_EN
            state_d = (is_div && b_zero) ? FIX : CALC;
`else
            state_d = CALC;
`endif
         end
         CALC: if (cnt_q == '0) state_d = FIX;
         FIX: begin
            state_d = IDLE;
            valid   = 1'b1;
         end
      endcase
      if (state_q != IDLE && (io_kill_i || !io_en_i)) begin
         state_d = IDLE;
         valid   = 1'b0;
      end
   end

   // State register and iterative datapath.
   always_ff @(posedge clock) begin
      // NOTE: datapath registers are reset as well, so outputs derived from them are clean after reset.
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= MD_OP_MULL;
         mode_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (io_en_i && !io_kill_i) begin
                  op_q   <= md_op_e'(io_md_operator_i);
                  mode_q <= io_signed_mode_i;
                  a_q    <= io_operand_a_i;
                  b_q    <= io_operand_b_i;
               end
            end
            ABS: begin
               neg_q_q  <= sa ^ sb;
               neg_r_q  <= sa;
               cnt_q    <= CNT_W'(ITER - 1);
               acc_hi_q <= '0;
               acc_lo_q <= is_div ? abs_a[XLEN-1:0] : abs_b[XLEN-1:0];
`ifdef MULTDIV_DIVZERO_SHORTCUT_EN
               if (is_div && b_zero) begin
                  acc_hi_q <= abs_a;
                  acc_lo_q <= '1;
               end
`endif
            end
            CALC: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (is_div) begin
                  acc_hi_q <= {1'b0, ge ? io_alu_adder_result_i : rem_sh[XLEN-1:0]};
                  acc_lo_q <= {acc_lo_q[XLEN-2:0], ge};
               end else begin
                  {acc_hi_q, acc_lo_q} <= {1'b0, mul_sum, acc_lo_q[XLEN-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

   // Sign correction of product, quotient and remainder.
   ibex_multdiv_negate #(.WIDTH(2*XLEN)) u_fix_prod (
      .neg(neg_q_q), .value({acc_hi_q[XLEN-1:0], acc_lo_q}), .result(prod_fixed)
   );
   ibex_multdiv_negate #(.WIDTH(XLEN)) u_fix_quot (
      .neg(neg_q_q & ~b_zero), .value(acc_lo_q), .result(quot_fixed)
   );
   ibex_multdiv_negate #(.WIDTH(XLEN)) u_fix_rem (
      .neg(neg_r_q), .value(acc_hi_q[XLEN-1:0]), .result(rem_fixed)
   );

   // Result selection by operator; forced to zero outside the valid cycle.
   always_comb begin
      result_raw = '0;
      case (op_q)
         MD_OP_MULL: result_raw = prod_fixed[XLEN-1:0];
         MD_OP_MULH: result_raw = prod_fixed[2*XLEN-1:XLEN];
         MD_OP_DIV:  result_raw = quot_fixed;
         MD_OP_REM:  result_raw = rem_fixed;
      endcase
   end

   assign io_valid_o  = valid;
   assign io_result_o = valid ? result_raw : '0;

endmodule

// File: tb/tb_ibex_multdiv_slow.sv
// Self-checking bench for ibex_multdiv_slow: directed operation table plus
// abort, reset and latency sequences. The bench models the shared ALU.
module tb_ibex_multdiv_slow;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        kill = 1'b0;
   logic [1:0]  md_op = 2'd0;
   logic [1:0]  mode = 2'd0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        alu_active;
   logic [5:0]  alu_operator;
   logic [31:0] alu_op_a, alu_op_b, alu_sum;
   logic        alu_cmp;
   logic        valid;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [1:0]  mode;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[14];

   always #5 clock = ~clock;

   // Shared ALU: subtract and unsigned >= compare.
   assign alu_sum = alu_op_a - alu_op_b;
   assign alu_cmp = (alu_op_a >= alu_op_b);

   ibex_multdiv_slow dut (
      .clock                     (clock),
      .reset                     (reset),
      .io_en_i                   (en),
      .io_kill_i                 (kill),
      .io_md_operator_i          (md_op),
      .io_signed_mode_i          (mode),
      .io_operand_a_i            (op_a),
      .io_operand_b_i            (op_b),
      .io_alu_active_o           (alu_active),
      .io_alu_operator_o         (alu_operator),
      .io_alu_operand_a_o        (alu_op_a),
      .io_alu_operand_b_o        (alu_op_b),
      .io_alu_adder_result_i     (alu_sum),
      .io_alu_comparison_result_i(alu_cmp),
      .io_valid_o                (valid),
      .io_result_o               (result)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [1:0] op, input logic [1:0] m,
                           input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      md_op = op;
      mode  = m;
      op_a  = a;
      op_b  = b;
      en    = 1'b1;
      kill  = 1'b0;
   endtask

   // Watches a number of cycles and requires that valid never rises.
   task automatic watch_no_valid(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock);
         #1;
         if (valid) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd0);
   endtask

   // Runs one operation to completion and checks result, latency and ALU usage.
   task automatic run_op(input vec_t v);
      int   lat;
      int   exp_lat;
      logic exp_active;
      logic done;
      exp_lat    = 34;
      exp_active = v.op[1];
`ifdef MULTDIV_DIVZERO_SHORTCUT_EN
      if (v.op[1] && v.b == 32'd0) begin
         exp_lat    = 2;
         exp_active = 1'b0;
      end
`endif
      start_op(v.op, v.mode, v.a, v.b);
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 60) begin
         @(posedge clock);
         #1;
         lat++;
         if (lat == 2) begin
            check({v.name, " alu_active"}, {31'd0, alu_active}, {31'd0, exp_active});
            check({v.name, " alu_operator"}, {26'd0, alu_operator},
                  exp_active ? 32'h16 : 32'h00);
         end
         if (valid) done = 1'b1;
      end
      if (!done) begin
         check({v.name, " valid timeout"}, 32'd0, 32'd1);
      end else begin
         check({v.name, " result"}, result, v.exp);
         check({v.name, " latency"}, lat, exp_lat);
         // en still high: the unit must drop valid and return to IDLE.
         @(posedge clock);
         #1;
         en = 1'b0;
         check({v.name, " valid pulse"}, {31'd0, valid}, 32'd0);
         check({v.name, " result idle"}, result, 32'd0);
      end
      en = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{"MUL 7*-3",          2'd0, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{"MULH min*min",      2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[2]  = '{"MULHU max*max",     2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3]  = '{"MULHSU -1*2",       2'd1, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[4]  = '{"DIV -7/2",          2'd2, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
      vecs[5]  = '{"REM -7%2",          2'd3, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[6]  = '{"DIVU max/1",        2'd2, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
      vecs[7]  = '{"DIV min/-1",        2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[8]  = '{"REM min%-1",        2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[9]  = '{"DIV by zero",       2'd2, 2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF};
      vecs[10] = '{"REM by zero",       2'd3, 2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
      vecs[11] = '{"MUL shift",         2'd0, 2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
      vecs[12] = '{"REMU 100%7",        2'd3, 2'b00, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002};
      vecs[13] = '{"MULHU 2^16*2^16",   2'd1, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};

      // Reset state.
      repeat (3) @(posedge clock);
      #1;
      check("reset valid", {31'd0, valid}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset alu_active", {31'd0, alu_active}, 32'd0);
      check("reset alu_operator", {26'd0, alu_operator}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) run_op(vecs[i]);

      // Kill in cycle 10 of a DIV: no result, back to IDLE.
      start_op(2'd2, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
      repeat (10) @(posedge clock);
      #1;
      check("kill busy before", {31'd0, alu_active}, 32'd1);
      kill = 1'b1;
      en   = 1'b0;
      @(posedge clock);
      #1;
      kill = 1'b0;
      check("kill alu released", {31'd0, alu_active}, 32'd0);
      watch_no_valid("kill no valid", 40);

      // en dropped in cycle 20 of a MUL: no result.
      start_op(2'd0, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD);
      repeat (20) @(posedge clock);
      #1;
      en = 1'b0;
      watch_no_valid("en drop no valid", 40);

      // A fresh MUL after the aborts completes normally.
      run_op(vecs[0]);

      // Synchronous reset in cycle 5 of a DIV.
      start_op(2'd2, 2'b00, 32'h0000_0064, 32'h0000_0007);
      repeat (5) @(posedge clock);
      #1;
      check("pre-reset alu_active", {31'd0, alu_active}, 32'd1);
      reset = 1'b1;
      en    = 1'b0;
      @(posedge clock);
      #1;
      check("midop reset valid", {31'd0, valid}, 32'd0);
      check("midop reset result", result, 32'd0);
      check("midop reset alu_active", {31'd0, alu_active}, 32'd0);
      check("midop reset alu_operator", {26'd0, alu_operator}, 32'd0);
      check("midop reset alu_op_a", alu_op_a, 32'd0);
      check("midop reset alu_op_b", alu_op_b, 32'd0);
      reset = 1'b0;
      watch_no_valid("reset no valid", 40);

      // Unit is usable again from IDLE.
      run_op(vecs[4]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
